// File: rtl/riscv_base_alu_arbiter.sv
// Two-port arbiter sharing one riscv_base_alu; one operation in flight, IDLE -> EXEC -> RESP.
// Optional performance counters are enabled by defining RISCV_ALU_ARB_PERF_EN.

`ifndef ALU_NONE
`define ALU_NONE                4'b0000
`define ALU_SHIFT_LEFT          4'b0001
`define ALU_SHIFT_RIGHT         4'b0010
`define ALU_SHIFT_RIGHT_ARITH   4'b0011
`define ALU_ADD                 4'b0100
`define ALU_SUB                 4'b0110
`define ALU_AND                 4'b0111
`define ALU_OR                  4'b1000
`define ALU_XOR                 4'b1001
`define ALU_LESS_THAN           4'b1010
`define ALU_LESS_THAN_SIGNED    4'b1011
`endif

module riscv_base_alu (
    input  logic [3:0]  alu_op_i,
    input  logic [31:0] alu_a_i,
    input  logic [31:0] alu_b_i,
    output logic [31:0] alu_p_o
);
    always_comb begin
        alu_p_o = alu_a_i;
        case (alu_op_i)
            `ALU_SHIFT_LEFT:        alu_p_o = alu_a_i << alu_b_i[4:0];
            `ALU_SHIFT_RIGHT:       alu_p_o = alu_a_i >> alu_b_i[4:0];
            `ALU_SHIFT_RIGHT_ARITH: alu_p_o = $unsigned($signed(alu_a_i) >>> alu_b_i[4:0]);
            `ALU_ADD:               alu_p_o = alu_a_i + alu_b_i;
            `ALU_SUB:               alu_p_o = alu_a_i - alu_b_i;
            `ALU_AND:               alu_p_o = alu_a_i & alu_b_i;
            `ALU_OR:                alu_p_o = alu_a_i | alu_b_i;
            `ALU_XOR:               alu_p_o = alu_a_i ^ alu_b_i;
            `ALU_LESS_THAN:         alu_p_o = {31'b0, alu_a_i < alu_b_i};
            `ALU_LESS_THAN_SIGNED:  alu_p_o = {31'b0, $signed(alu_a_i) < $signed(alu_b_i)};
            default:                alu_p_o = alu_a_i;
        endcase
    end
endmodule

module riscv_base_alu_arbiter #(
    parameter int RR_EN     = 1,
    parameter int RESET_PTR = 0,
    parameter int PERF_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [3:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [3:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        req1_ready_o,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_res_o,
    input  logic        rsp_ready_i,
    input  logic        flush_i,
    output logic        busy_o
`ifdef RISCV_ALU_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_grant0_o,
    output logic [PERF_W-1:0] perf_grant1_o,
    output logic [PERF_W-1:0] perf_conflict_o
`endif
);
    if (PERF_W < 1 || RESET_PTR < 0 || RESET_PTR > 1) begin : g_bad_param
        $error("riscv_base_alu_arbiter: PERF_W must be >= 1 and RESET_PTR 0 or 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_res_q, rsp_res_d;
    logic        sel1, can_grant, grant0, grant1;
    logic [31:0] alu_res;

    riscv_base_alu u_alu (
        .alu_op_i (op_q),
        .alu_a_i  (a_q),
        .alu_b_i  (b_q),
        .alu_p_o  (alu_res)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        // sel1 names the port that wins a tie; fixed priority always favours port 0
        sel1      = (RR_EN != 0) ? ptr_q : 1'b0;
        can_grant = (state_q == ST_IDLE) && !flush_i && !rst_i;
        grant0    = can_grant && req0_valid_i && (!req1_valid_i || !sel1);
        grant1    = can_grant && req1_valid_i && (!req0_valid_i || sel1);
        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    op_d = req0_op_i; a_d = req0_a_i; b_d = req0_b_i;
                    id_d = 1'b0; ptr_d = 1'b1; state_d = ST_EXEC;
                end else if (grant1) begin
                    op_d = req1_op_i; a_d = req1_a_i; b_d = req1_b_i;
                    id_d = 1'b1; ptr_d = 1'b0; state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_res_d   = alu_res;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flushed operation never reaches the result register
        if (flush_i) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_res_d   = rsp_res_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= (RESET_PTR != 0);
            op_q        <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_res_o    = rsp_res_q;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef RISCV_ALU_ARB_PERF_EN
    logic [PERF_W-1:0] grant0_cnt_q, grant0_cnt_d;
    logic [PERF_W-1:0] grant1_cnt_q, grant1_cnt_d;
    logic [PERF_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant0_cnt_d   = grant0_cnt_q + (grant0 ? PERF_W'(1) : PERF_W'(0));
        grant1_cnt_d   = grant1_cnt_q + (grant1 ? PERF_W'(1) : PERF_W'(0));
        // One count per cycle in which any requester is left waiting
        conflict_cnt_d = conflict_cnt_q +
            (((req0_valid_i && !grant0) || (req1_valid_i && !grant1)) ? PERF_W'(1) : PERF_W'(0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant0_cnt_q   <= grant0_cnt_d;
            grant1_cnt_q   <= grant1_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign perf_grant0_o   = grant0_cnt_q;
    assign perf_grant1_o   = grant1_cnt_q;
    assign perf_conflict_o = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_base_alu_arbiter.sv
// Scoreboard bench for riscv_base_alu_arbiter: a round-robin instance and a fixed-priority instance.
// Build with RISCV_ALU_ARB_PERF_EN defined to also check the performance counters.
module tb_riscv_base_alu_arbiter;
    localparam logic [3:0] OP_SHL = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;

    // Handshake: a request is taken when valid & ready are both high in the same cycle;
    // a response is taken when rsp_valid & rsp_ready are both high in the same cycle.

    logic clk, rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic        rr_v0, rr_v1, rr_r0, rr_r1, rr_rsp_valid, rr_rsp_id, rr_rsp_ready, rr_flush, rr_busy;
    logic [3:0]  rr_op0, rr_op1;
    logic [31:0] rr_a0, rr_b0, rr_a1, rr_b1, rr_rsp_res;
    logic        fp_v0, fp_v1, fp_r0, fp_r1, fp_rsp_valid, fp_rsp_id, fp_rsp_ready, fp_flush, fp_busy;
    logic [3:0]  fp_op0, fp_op1;
    logic [31:0] fp_a0, fp_b0, fp_a1, fp_b1, fp_rsp_res;
`ifdef RISCV_ALU_ARB_PERF_EN
    logic [31:0] rr_pg0, rr_pg1, rr_pc, fp_pg0, fp_pg1, fp_pc;
`endif

    logic [32:0] exp_q[$];
    logic [32:0] fp_exp_q[$];
    logic        grant_log[$];
    logic [32:0] rr_e, fp_e;

    riscv_base_alu_arbiter #(.RR_EN(1), .RESET_PTR(0), .PERF_W(32)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(rr_v0), .req0_op_i(rr_op0), .req0_a_i(rr_a0), .req0_b_i(rr_b0), .req0_ready_o(rr_r0),
        .req1_valid_i(rr_v1), .req1_op_i(rr_op1), .req1_a_i(rr_a1), .req1_b_i(rr_b1), .req1_ready_o(rr_r1),
        .rsp_valid_o(rr_rsp_valid), .rsp_id_o(rr_rsp_id), .rsp_res_o(rr_rsp_res), .rsp_ready_i(rr_rsp_ready),
        .flush_i(rr_flush), .busy_o(rr_busy)
`ifdef RISCV_ALU_ARB_PERF_EN
        , .perf_grant0_o(rr_pg0), .perf_grant1_o(rr_pg1), .perf_conflict_o(rr_pc)
`endif
    );

    riscv_base_alu_arbiter #(.RR_EN(0), .RESET_PTR(0), .PERF_W(32)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(fp_v0), .req0_op_i(fp_op0), .req0_a_i(fp_a0), .req0_b_i(fp_b0), .req0_ready_o(fp_r0),
        .req1_valid_i(fp_v1), .req1_op_i(fp_op1), .req1_a_i(fp_a1), .req1_b_i(fp_b1), .req1_ready_o(fp_r1),
        .rsp_valid_o(fp_rsp_valid), .rsp_id_o(fp_rsp_id), .rsp_res_o(fp_rsp_res), .rsp_ready_i(fp_rsp_ready),
        .flush_i(fp_flush), .busy_o(fp_busy)
`ifdef RISCV_ALU_ARB_PERF_EN
        , .perf_grant0_o(fp_pg0), .perf_grant1_o(fp_pg1), .perf_conflict_o(fp_pc)
`endif
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every response handshake
    always @(negedge clk) begin
        if (!rst && rr_rsp_valid && rr_rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rr_unexpected_rsp: actual id=%0d res=%h required=no response", rr_rsp_id, rr_rsp_res);
            end else begin
                rr_e = exp_q.pop_front();
                check("rr_rsp_id", 64'(rr_rsp_id), 64'(rr_e[32]));
                check("rr_rsp_res", 64'(rr_rsp_res), 64'(rr_e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && fp_rsp_valid && fp_rsp_ready) begin
            if (fp_exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL fp_unexpected_rsp: actual id=%0d res=%h required=no response", fp_rsp_id, fp_rsp_res);
            end else begin
                fp_e = fp_exp_q.pop_front();
                check("fp_rsp_id", 64'(fp_rsp_id), 64'(fp_e[32]));
                check("fp_rsp_res", 64'(fp_rsp_res), 64'(fp_e[31:0]));
            end
        end
    end

    // Drivers: entered and left just after a rising edge
    task automatic send0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit last, input bit expect_rsp);
        int cnt = 0;
        bit ok = 0;
        rr_v0 = 1'b1; rr_op0 = op; rr_a0 = a; rr_b0 = b;
        while (!ok && cnt < 100) begin
            @(negedge clk);
            if (rr_r0) ok = 1; else cnt++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send0_timeout: actual=no ready0 in 100 cycles required=accept");
        end else begin
            grant_log.push_back(1'b0);
            if (expect_rsp) exp_q.push_back({1'b0, exp_res});
        end
        @(posedge clk); #1;
        if (last || !ok) rr_v0 = 1'b0;
    endtask

    task automatic send1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit last, input bit expect_rsp);
        int cnt = 0;
        bit ok = 0;
        rr_v1 = 1'b1; rr_op1 = op; rr_a1 = a; rr_b1 = b;
        while (!ok && cnt < 100) begin
            @(negedge clk);
            if (rr_r1) ok = 1; else cnt++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send1_timeout: actual=no ready1 in 100 cycles required=accept");
        end else begin
            grant_log.push_back(1'b1);
            if (expect_rsp) exp_q.push_back({1'b1, exp_res});
        end
        @(posedge clk); #1;
        if (last || !ok) rr_v1 = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while ((exp_q.size() != 0 || rr_busy) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL rr_drain_timeout: actual pending=%0d busy=%0b required=0/0", exp_q.size(), rr_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_rr_reset(input string tag);
        check({tag, "_rsp_valid"}, 64'(rr_rsp_valid), 64'd0);
        check({tag, "_rsp_id"}, 64'(rr_rsp_id), 64'd0);
        check({tag, "_rsp_res"}, 64'(rr_rsp_res), 64'd0);
        check({tag, "_busy"}, 64'(rr_busy), 64'd0);
`ifdef RISCV_ALU_ARB_PERF_EN
        check({tag, "_perf_grant0"}, 64'(rr_pg0), 64'd0);
        check({tag, "_perf_grant1"}, 64'(rr_pg1), 64'd0);
        check({tag, "_perf_conflict"}, 64'(rr_pc), 64'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        rr_v0 = 1'b1; rr_v1 = 1'b1; rr_op0 = '0; rr_op1 = '0;
        rr_a0 = '0; rr_b0 = '0; rr_a1 = '0; rr_b1 = '0;
        rr_rsp_ready = 1'b1; rr_flush = 1'b0;
        fp_v0 = 1'b0; fp_v1 = 1'b0; fp_op0 = '0; fp_op1 = '0;
        fp_a0 = '0; fp_b0 = '0; fp_a1 = '0; fp_b1 = '0;
        fp_rsp_ready = 1'b1; fp_flush = 1'b0;

        // Reset state, with both requests already asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rr_reset("reset");
        check("reset_ready0", 64'(rr_r0), 64'd0);
        check("reset_ready1", 64'(rr_r1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention, round robin from port 0: expect grants 0,1,0,1
        fork
            begin
                send0(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
                send0(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b1);
            end
            begin
                send1(OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
                send1(OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 1'b1, 1'b1);
            end
        join
        wait_drain();
        check("rr_grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("rr_grant_order0", 64'(grant_log[0]), 64'd0);
            check("rr_grant_order1", 64'(grant_log[1]), 64'd1);
            check("rr_grant_order2", 64'(grant_log[2]), 64'd0);
            check("rr_grant_order3", 64'(grant_log[3]), 64'd1);
        end
`ifdef RISCV_ALU_ARB_PERF_EN
        // Someone waits in each of the 3 cycles of the first three grants; the last is uncontended
        check("perf_grant0", 64'(rr_pg0), 64'd2);
        check("perf_grant1", 64'(rr_pg1), 64'd2);
        check("perf_conflict", 64'(rr_pc), 64'd9);
`endif

        // Single op: 5 + 7, response two cycles after accept
        send0(OP_ADD, 32'd5, 32'd7, 32'h0000_000C, 1'b1, 1'b1);
        @(negedge clk);
        check("single_busy_exec", 64'(rr_busy), 64'd1);
        check("single_valid_exec", 64'(rr_rsp_valid), 64'd0);
        @(negedge clk);
        check("single_valid_at_n2", 64'(rr_rsp_valid), 64'd1);
        check("single_res_at_n2", 64'(rr_rsp_res), 64'h0000_000C);
        @(negedge clk);
        check("single_busy_at_n3", 64'(rr_busy), 64'd0);
        @(posedge clk); #1;
        wait_drain();

        // Backpressure: hold the XOR result for 5 cycles while port 1 waits
        rr_rsp_ready = 1'b0;
        send0(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b1, 1'b1);
        fork
            send1(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1, 1'b1);
            begin
                @(negedge clk);
                check("bp_ready1_exec", 64'(rr_r1), 64'd0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_valid_hold", 64'(rr_rsp_valid), 64'd1);
                    check("bp_res_hold", 64'(rr_rsp_res), 64'hF00F_F00F);
                    check("bp_ready0_low", 64'(rr_r0), 64'd0);
                    check("bp_ready1_low", 64'(rr_r1), 64'd0);
                end
                @(posedge clk); #1;
                rr_rsp_ready = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_idle_after_release", 64'(rr_busy), 64'd0);
                check("bp_ready1_after_release", 64'(rr_r1), 64'd1);
            end
        join
        wait_drain();

        // Flush in EXEC: no response, IDLE next cycle
        send0(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0);
        rr_flush = 1'b1;
        @(posedge clk); #1;
        rr_flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(rr_busy), 64'd0);
        check("flush_no_valid", 64'(rr_rsp_valid), 64'd0);
        @(posedge clk); #1;
        // Flush in IDLE blocks the accept for that cycle
        rr_v0 = 1'b1; rr_op0 = OP_ADD; rr_a0 = 32'd4; rr_b0 = 32'd5;
        rr_flush = 1'b1;
        @(negedge clk);
        check("flush_idle_ready0", 64'(rr_r0), 64'd0);
        @(posedge clk); #1;
        rr_flush = 1'b0;
        send0(OP_ADD, 32'd4, 32'd5, 32'd9, 1'b1, 1'b1);
        wait_drain();

        // Reset while port 1's op is in EXEC
        send1(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0);
        rst = 1'b1;
        rr_v0 = 1'b1;
        @(negedge clk);
        check("rst_ready0", 64'(rr_r0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rr_v0 = 1'b0;
        @(negedge clk);
        check_rr_reset("midrst");
        @(posedge clk); #1;

        // Fixed priority: port 0 takes every grant while it stays valid
        fp_v0 = 1'b1; fp_op0 = OP_AND; fp_a0 = 32'hF0F0_1234; fp_b0 = 32'h0FF0_FFFF;
        fp_v1 = 1'b1; fp_op1 = OP_OR;  fp_a1 = 32'd1;          fp_b1 = 32'd2;
        for (int g = 0; g < 4; g++) begin
            int cnt = 0;
            @(negedge clk);
            while (!(fp_r0 || fp_r1) && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("fp_grant_port0", 64'(fp_r0), 64'd1);
            check("fp_port1_waits", 64'(fp_r1), 64'd0);
            fp_exp_q.push_back({1'b0, 32'h00F0_1234});
            @(posedge clk); #1;
        end
        fp_v0 = 1'b0;
        begin
            int cnt = 0;
            @(negedge clk);
            while (!(fp_r0 || fp_r1) && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("fp_grant_port1", 64'(fp_r1), 64'd1);
            fp_exp_q.push_back({1'b1, 32'h0000_0003});
            @(posedge clk); #1;
            fp_v1 = 1'b0;
        end
        begin
            int cnt = 0;
            while ((fp_exp_q.size() != 0 || fp_busy) && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
        end
        @(posedge clk); #1;
        check("fp_exp_q_empty", 64'(fp_exp_q.size()), 64'd0);
        check("rr_exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
